// File: rtl/prime_gen_pkg.sv
// rtl/prime_gen_pkg.sv - shared types and constants for the prime stream generator
package prime_gen_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int FIRST_ODD_PRIME = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_EMIT,
        ST_NEXT,
        ST_CHECK,
        ST_MOD_WAIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/seq_mod_unit.sv
// rtl/seq_mod_unit.sv - sequential restoring remainder unit
// Load cycle folds in the dividend MSB, then WIDTH shift/subtract steps follow.
module seq_mod_unit
    import prime_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mod_start,
    input  logic [WIDTH:0]   dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             mod_done,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] bits_q, bits_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    // rem < divisor holds on entry, so the shifted value always fits in WIDTH+1 bits
    function automatic logic [WIDTH-1:0] rstep(input logic [WIDTH-1:0] r,
                                               input logic             b,
                                               input logic [WIDTH-1:0] d);
        logic [WIDTH:0] t;
        t = {r, b};
        if (t >= {1'b0, d}) begin
            t = t - {1'b0, d};
        end
        return t[WIDTH-1:0];
    endfunction

    always_comb begin
        rem_d  = rem_q;
        bits_d = bits_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (mod_start) begin
            rem_d  = rstep('0, dividend[WIDTH], divisor);
            bits_d = dividend[WIDTH-1:0];
            div_d  = divisor;
            cnt_d  = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            rem_d  = rstep(rem_q, bits_q[WIDTH-1], div_q);
            bits_d = bits_q << 1;
            cnt_d  = cnt_q - 1'b1;
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            bits_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            bits_q <= bits_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign mod_done  = done_q;
    assign remainder = rem_q;

endmodule

// File: rtl/prime_stream_gen.sv
// rtl/prime_stream_gen.sv - streams every prime in [2, limit] by odd trial division
// Define PRIME_COUNT_EN to add the prime_count output.
module prime_stream_gen
    import prime_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] prime_out,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic             busy,
    output logic             done
`ifdef PRIME_COUNT_EN
    ,
    output logic [WIDTH-1:0] prime_count
`endif
);

    localparam int PW = 2 * WIDTH + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH:0]   c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   c_plus2;
    logic [WIDTH:0]   limit_ext;
    logic             sq_gt;
    logic             mod_start;
    logic             mod_done;
    logic [WIDTH-1:0] remainder;
`ifdef PRIME_COUNT_EN
    logic [WIDTH-1:0] count_q, count_d;
`endif

    assign c_plus2   = c_q + (WIDTH+1)'(2);
    assign limit_ext = {1'b0, limit_q};
    assign sq_gt     = (PW'(d_q) * PW'(d_q)) > PW'(c_q);

    seq_mod_unit #(.WIDTH(WIDTH)) u_mod (
        .clk       (clk),
        .rst       (rst),
        .mod_start (mod_start),
        .dividend  (c_q),
        .divisor   (d_q),
        .mod_done  (mod_done),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            c_q     <= '0;
            d_q     <= '0;
`ifdef PRIME_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            c_q     <= c_d;
            d_q     <= d_d;
`ifdef PRIME_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        c_d     = c_q;
        d_d     = d_q;
`ifdef PRIME_COUNT_EN
        count_d = count_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    limit_d = limit;
                    state_d = ST_INIT;
`ifdef PRIME_COUNT_EN
                    count_d = '0;
`endif
                end
            end
            ST_INIT: begin
                if (limit_q < WIDTH'(2)) begin
                    state_d = ST_DONE;
                end else begin
                    c_d     = (WIDTH+1)'(2);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (prime_ready) begin
`ifdef PRIME_COUNT_EN
                    count_d = count_q + 1'b1;
`endif
                    // 2 is the only even prime; afterwards only odd candidates are visited
                    if (c_q == (WIDTH+1)'(2)) begin
                        c_d     = (WIDTH+1)'(FIRST_ODD_PRIME);
                        d_d     = WIDTH'(FIRST_ODD_PRIME);
                        state_d = ((WIDTH+1)'(FIRST_ODD_PRIME) <= limit_ext) ? ST_CHECK : ST_DONE;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                c_d = c_plus2;
                if (c_plus2 > limit_ext) begin
                    state_d = ST_DONE;
                end else begin
                    d_d     = WIDTH'(FIRST_ODD_PRIME);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = sq_gt ? ST_EMIT : ST_MOD_WAIT;
            end
            ST_MOD_WAIT: begin
                if (mod_done) begin
                    if (remainder == '0) begin
                        state_d = ST_NEXT;
                    end else begin
                        d_d     = d_q + WIDTH'(2);
                        state_d = ST_CHECK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prime_valid = (state_q == ST_EMIT);
        prime_out   = (state_q == ST_EMIT) ? c_q[WIDTH-1:0] : '0;
        busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done        = (state_q == ST_DONE);
        mod_start   = (state_q == ST_CHECK) && !sq_gt;
    end

`ifdef PRIME_COUNT_EN
    assign prime_count = count_q;
`endif

endmodule

// File: tb/tb_prime_stream_gen.sv
// tb/tb_prime_stream_gen.sv - scoreboard bench for prime_stream_gen
module tb_prime_stream_gen;
    import prime_gen_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] limit;
    logic [W-1:0] prime_out;
    logic         prime_valid;
    logic         prime_ready;
    logic         busy;
    logic         done;
`ifdef PRIME_COUNT_EN
    logic [W-1:0] prime_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int got[$];

    prime_stream_gen #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .limit       (limit),
        .prime_out   (prime_out),
        .prime_valid (prime_valid),
        .prime_ready (prime_ready),
        .busy        (busy),
        .done        (done)
`ifdef PRIME_COUNT_EN
        ,
        .prime_count (prime_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit is_prime(int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++) begin
            if (n % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_expected(int lim);
        for (int p = 2; p <= lim; p++) begin
            if (is_prime(p)) exp_q.push_back(p);
        end
    endtask

    task automatic start_run(int lim);
        limit = W'(lim);
        start = 1'b1;
        push_expected(lim);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records handshakes until done; optionally pulses start (limit=3) at cycle poke_at
    task automatic collect(int max_cycles, int poke_at, output bit timed_out, output bit valid_after);
        timed_out   = 1'b1;
        valid_after = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (prime_valid && prime_ready) got.push_back(int'(prime_out));
            if (i == poke_at) begin
                limit = W'(3);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (prime_valid) valid_after = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; prime_ready = 1'b1; limit = '0;
        repeat (2) @(negedge clk);
        vectors++; if (prime_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", prime_valid); end
        vectors++; if (prime_out !== '0) begin miscompares++; $display("FAIL reset_out got %0d want 0", prime_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_limit20();
        bit to, va;
        int e;
        got.delete(); exp_q.delete();
        start_run(20);
        collect(3000, -1, to, va);
        vectors++; if (to) begin miscompares++; $display("FAIL l20_timeout got timeout want done"); end
        foreach (got[i]) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (got[i] !== e) begin miscompares++; $display("FAIL l20_stream[%0d] got %0d want %0d", i, got[i], e); end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL l20_missing got %0d left want 0", exp_q.size()); end
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL l20_end done=%b busy=%b want 1/0", done, busy); end
        vectors++; if (va) begin miscompares++; $display("FAIL l20_valid_after_done got 1 want 0"); end
`ifdef PRIME_COUNT_EN
        vectors++; if (prime_count !== W'(8)) begin miscompares++; $display("FAIL l20_count got %0d want 8", prime_count); end
`endif
    endtask

    task automatic test_small_limits();
        bit seen;
        for (int lim = 1; lim >= 0; lim--) begin
            exp_q.delete();
            start_run(lim);
            seen = prime_valid;
            @(negedge clk);
            seen = seen | prime_valid;
            vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL small%0d_done got %b want 1", lim, done); end
            vectors++; if (seen) begin miscompares++; $display("FAIL small%0d_valid got 1 want 0", lim); end
            vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL small%0d_model got %0d want 0", lim, exp_q.size()); end
        end
    endtask

    task automatic test_limit255();
        bit to, va;
        int e;
        int sq[6] = '{9, 25, 49, 121, 169, 225};
        got.delete(); exp_q.delete();
        start_run(255);
        collect(40000, -1, to, va);
        vectors++; if (to) begin miscompares++; $display("FAIL l255_timeout got timeout want done"); end
        vectors++; if (got.size() != 54) begin miscompares++; $display("FAIL l255_count got %0d want 54", got.size()); end
        if (got.size() > 0) begin
            vectors++; if (got[0] !== 2) begin miscompares++; $display("FAIL l255_first got %0d want 2", got[0]); end
            vectors++; if (got[got.size()-1] !== 251) begin miscompares++; $display("FAIL l255_last got %0d want 251", got[got.size()-1]); end
        end
        foreach (sq[k]) begin
            vectors++;
            foreach (got[i]) begin
                if (got[i] == sq[k]) begin miscompares++; $display("FAIL l255_square got %0d want absent", sq[k]); end
            end
        end
        foreach (got[i]) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (got[i] !== e) begin miscompares++; $display("FAIL l255_stream[%0d] got %0d want %0d", i, got[i], e); end
        end
    endtask

    task automatic test_backpressure();
        bit held = 1'b0;
        int e;
        int idx = -1;
        got.delete(); exp_q.delete();
        start_run(10);
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (prime_valid && prime_out == W'(5) && !held) begin
                held = 1'b1;
                prime_ready = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    vectors++;
                    if (prime_valid !== 1'b1 || prime_out !== W'(5)) begin
                        miscompares++; $display("FAIL bp_hold[%0d] valid=%b out=%0d want 1/5", j, prime_valid, prime_out);
                    end
                end
                prime_ready = 1'b1;
            end
            if (prime_valid && prime_ready) got.push_back(int'(prime_out));
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL bp_timeout got done=0 want 1"); end
        foreach (got[i]) if (got[i] == 5) idx = i;
        vectors++;
        if (idx < 0 || idx + 1 >= got.size()) begin miscompares++; $display("FAIL bp_after5 got none want 7"); end
        else if (got[idx+1] !== 7) begin miscompares++; $display("FAIL bp_after5 got %0d want 7", got[idx+1]); end
        foreach (got[i]) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (got[i] !== e) begin miscompares++; $display("FAIL bp_stream[%0d] got %0d want %0d", i, got[i], e); end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_missing got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midrun();
        bit to, va, found = 1'b0, seen = 1'b0;
        int e;
        got.delete(); exp_q.delete();
        start_run(100);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (dut.state_q == ST_CHECK && dut.c_q == 9'd53) begin found = 1'b1; break; end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL rst_mid_reach got not-found want c=53"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (prime_valid !== 1'b0 || prime_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_outputs v=%b o=%0d b=%b d=%b want all 0", prime_valid, prime_out, busy, done);
        end
        vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL rst_mid_state got %0d want IDLE", dut.state_q); end
`ifdef PRIME_COUNT_EN
        vectors++; if (prime_count !== '0) begin miscompares++; $display("FAIL rst_mid_count got %0d want 0", prime_count); end
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | prime_valid | busy;
        end
        vectors++; if (seen) begin miscompares++; $display("FAIL rst_mid_idle got activity want none"); end
        exp_q.delete();
        start_run(5);
        collect(3000, -1, to, va);
        vectors++; if (to) begin miscompares++; $display("FAIL rst_mid_timeout got timeout want done"); end
        foreach (got[i]) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (got[i] !== e) begin miscompares++; $display("FAIL rst_mid_stream[%0d] got %0d want %0d", i, got[i], e); end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rst_mid_missing got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_start_while_busy();
        bit to, va;
        int e;
        got.delete(); exp_q.delete();
        start_run(20);
        collect(3000, 3, to, va);
        vectors++; if (to) begin miscompares++; $display("FAIL busy_start_timeout got timeout want done"); end
        foreach (got[i]) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (got[i] !== e) begin miscompares++; $display("FAIL busy_start_stream[%0d] got %0d want %0d", i, got[i], e); end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL busy_start_missing got %0d left want 0", exp_q.size()); end
        vectors++; if (va) begin miscompares++; $display("FAIL busy_start_valid_after got 1 want 0"); end
`ifdef PRIME_COUNT_EN
        vectors++; if (prime_count !== W'(8)) begin miscompares++; $display("FAIL busy_start_count got %0d want 8", prime_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_limit20();
        test_small_limits();
        test_limit255();
        test_backpressure();
        test_reset_midrun();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
